// File: rtl/basic_ndro_pkg.sv
// Shared defaults and event type for the basic_ndro NDRO cell model.
// Holds the q-resolution rule so set/reset arbitration lives in one place.
package basic_ndro_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int READ_PERIOD_DEF = 1;
   localparam bit INIT_STATE_DEF  = 1'b0;
   localparam bit RESET_WINS_DEF  = 1'b1;

   typedef struct packed {
      logic set_evt;
      logic reset_evt;
   } ndro_evt_t;

   // Next stored bit given this cycle's events; coinciding events follow reset_wins.
   function automatic logic resolve_q(input ndro_evt_t evt, input logic q, input bit reset_wins);
      logic nq;
      nq = q;
      if (evt.set_evt && evt.reset_evt) begin
         nq = reset_wins ? 1'b0 : 1'b1;
      end else if (evt.set_evt) begin
         nq = 1'b1;
      end else if (evt.reset_evt) begin
         nq = 1'b0;
      end
      return nq;
   endfunction

endpackage

// File: rtl/basic_ndro_sync.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// The detector output is a single-cycle pulse per synchronized low-to-high transition.
module basic_ndro_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic evt
);

   logic [STAGES-1:0] sync_ff;
   logic              prev;

   // History clears on reset, so a level already high at release is seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
         prev    <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[STAGES-2:0], async_in};
         prev    <= sync_ff[STAGES-1];
      end
   end

   assign evt = sync_ff[STAGES-1] & ~prev;

endmodule

// File: rtl/basic_ndro.sv
// Digital stand-in for a superconducting NDRO storage cell with periodic readout.
// Define BASIC_NDRO_ERR_EN to add a sticky `err` output flagging coinciding set/reset events.
module basic_ndro
   import basic_ndro_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int READ_PERIOD = READ_PERIOD_DEF,
   parameter bit INIT_STATE  = INIT_STATE_DEF,
   parameter bit RESET_WINS  = RESET_WINS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set,
   input  logic reset,
   output logic out
`ifdef BASIC_NDRO_ERR_EN
   ,
   output logic err
`endif
);

   localparam int CNT_W = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;

   ndro_evt_t         evt;
   logic              q;
   logic              q_next;
   logic [CNT_W-1:0]  cnt;
   logic              read_slot;

   basic_ndro_sync #(.STAGES(SYNC_STAGES)) u_sync_set (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (set),
      .evt      (evt.set_evt)
   );

   basic_ndro_sync #(.STAGES(SYNC_STAGES)) u_sync_reset (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (reset),
      .evt      (evt.reset_evt)
   );

   assign read_slot = (cnt == CNT_W'(READ_PERIOD - 1));

   always_comb begin
      q_next = resolve_q(evt, q, RESET_WINS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= INIT_STATE;
         cnt <= '0;
      end else begin
         q   <= q_next;
         cnt <= read_slot ? '0 : cnt + CNT_W'(1);
      end
   end

   // Readout samples q only in the last slot of each period; q itself is never touched here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= INIT_STATE;
      end else if (read_slot) begin
         out <= q;
      end
   end

`ifdef BASIC_NDRO_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (evt.set_evt && evt.reset_evt) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_basic_ndro.sv
// Directed bench for basic_ndro: three instances (default, RESET_WINS=0, READ_PERIOD=4) share stimulus.
// Edge numbers in comments count rising clk edges since rst_n release.
module tb_basic_ndro;

   logic clk;
   logic rst_n;
   logic set;
   logic reset;
   logic out_dflt;
   logic out_rw0;
   logic out_rp4;
`ifdef BASIC_NDRO_ERR_EN
   logic err_dflt;
   logic err_rw0;
   logic err_rp4;
`endif

   int total;
   int bad;

   basic_ndro dut_dflt (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (set),
      .reset (reset),
      .out   (out_dflt)
`ifdef BASIC_NDRO_ERR_EN
      ,
      .err   (err_dflt)
`endif
   );

   basic_ndro #(.RESET_WINS(1'b0)) dut_rw0 (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (set),
      .reset (reset),
      .out   (out_rw0)
`ifdef BASIC_NDRO_ERR_EN
      ,
      .err   (err_rw0)
`endif
   );

   basic_ndro #(.READ_PERIOD(4)) dut_rp4 (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (set),
      .reset (reset),
      .out   (out_rp4)
`ifdef BASIC_NDRO_ERR_EN
      ,
      .err   (err_rp4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      set   = 1'b1;
      reset = 1'b0;

      // Reset held with set high: nothing may leak through.
      applyStimulus(3);
      checkOutput("rst_hold_dflt", out_dflt, 1'b0);
      checkOutput("rst_hold_rw0", out_rw0, 1'b0);
      checkOutput("rst_hold_rp4", out_rp4, 1'b0);
`ifdef BASIC_NDRO_ERR_EN
      checkOutput("rst_hold_err", err_dflt, 1'b0);
`endif

      rst_n = 1'b1;
      applyStimulus(3);
      checkOutput("rel_e3_dflt", out_dflt, 1'b0);
      applyStimulus(1);
      checkOutput("rel_e4_dflt", out_dflt, 1'b1);
      checkOutput("rel_e4_rw0", out_rw0, 1'b1);
      checkOutput("rel_e4_rp4", out_rp4, 1'b1);

      set = 1'b0;
      applyStimulus(6);
      reset = 1'b1;
      applyStimulus(3);
      checkOutput("clr_e13_dflt", out_dflt, 1'b1);
      applyStimulus(1);
      checkOutput("clr_e14_dflt", out_dflt, 1'b0);
      checkOutput("clr_e14_rw0", out_rw0, 1'b0);
      applyStimulus(1);
      checkOutput("clr_e15_rp4", out_rp4, 1'b1);
      applyStimulus(1);
      checkOutput("clr_e16_rp4", out_rp4, 1'b0);

      applyStimulus(4);
      reset = 1'b0;
      applyStimulus(4);
      checkOutput("clr_stay_dflt", out_dflt, 1'b0);

      // Set rises at edge 25, mid-period for the READ_PERIOD=4 instance.
      applyStimulus(1);
      set = 1'b1;
      applyStimulus(3);
      checkOutput("set_e28_dflt", out_dflt, 1'b0);
      checkOutput("set_e28_rp4", out_rp4, 1'b0);
      applyStimulus(1);
      checkOutput("set_e29_dflt", out_dflt, 1'b1);
      applyStimulus(2);
      checkOutput("set_e31_rp4", out_rp4, 1'b0);
      applyStimulus(1);
      checkOutput("set_e32_rp4", out_rp4, 1'b1);

      applyStimulus(3);
      set = 1'b0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1);
         checkOutput("ndro_dflt", out_dflt, 1'b1);
         checkOutput("ndro_rp4", out_rp4, 1'b1);
      end

      // Coinciding events from q=1: reset-wins clears, set-wins holds 1.
      set   = 1'b1;
      reset = 1'b1;
      applyStimulus(2);
`ifdef BASIC_NDRO_ERR_EN
      checkOutput("both_e87_err", err_dflt, 1'b0);
`endif
      applyStimulus(1);
`ifdef BASIC_NDRO_ERR_EN
      checkOutput("both_e88_err", err_dflt, 1'b1);
      checkOutput("both_e88_err_rw0", err_rw0, 1'b1);
`endif
      applyStimulus(1);
      checkOutput("both_e89_dflt", out_dflt, 1'b0);
      checkOutput("both_e89_rw0", out_rw0, 1'b1);
      applyStimulus(3);
      checkOutput("both_e92_rp4", out_rp4, 1'b0);

      applyStimulus(3);
      set   = 1'b0;
      reset = 1'b0;
      applyStimulus(5);
      reset = 1'b1;
      applyStimulus(4);
      checkOutput("clr2_dflt", out_dflt, 1'b0);
      checkOutput("clr2_rw0", out_rw0, 1'b0);
      applyStimulus(1);
      reset = 1'b0;

      // Coinciding events from q=0: only the set-wins instance changes.
      applyStimulus(5);
      set   = 1'b1;
      reset = 1'b1;
      applyStimulus(4);
      checkOutput("both2_dflt", out_dflt, 1'b0);
      checkOutput("both2_rw0", out_rw0, 1'b1);
`ifdef BASIC_NDRO_ERR_EN
      checkOutput("both2_err_sticky", err_dflt, 1'b1);
`endif

      applyStimulus(6);
      set   = 1'b0;
      reset = 1'b0;
      applyStimulus(5);
      set = 1'b1;
      applyStimulus(4);
      checkOutput("set2_dflt", out_dflt, 1'b1);
      applyStimulus(1);
      set = 1'b0;
      applyStimulus(2);

      // Asynchronous reset between clock edges.
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_dflt", out_dflt, 1'b0);
      checkOutput("async_rst_rw0", out_rw0, 1'b0);
`ifdef BASIC_NDRO_ERR_EN
      checkOutput("async_rst_err", err_dflt, 1'b0);
`endif
      applyStimulus(2);
      rst_n = 1'b1;
      applyStimulus(6);
      checkOutput("post_rst_dflt", out_dflt, 1'b0);
      checkOutput("post_rst_rw0", out_rw0, 1'b0);
      checkOutput("post_rst_rp4", out_rp4, 1'b0);
`ifdef BASIC_NDRO_ERR_EN
      checkOutput("post_rst_err", err_dflt, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
